// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply array and its operand feeders.
// Holds array geometry defaults, feeder FSM encoding and lane slicing helpers.
package matmul_pkg;

    localparam int MM_N = 4;
    localparam int MM_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feed_state_t;

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    function automatic int bus_width(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/skew_lane_delay.sv
// Fixed-depth shift register carrying one lane's data and valid tag.
// Depth D gives a D-cycle latency from din to dout.
module skew_lane_delay #(
    parameter int D  = 1,
    parameter int WD = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [WD-1:0] din,
    output logic [WD-1:0] dout
);

    logic [WD-1:0] sr [D];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < D; k++) begin
                sr[k] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int k = 1; k < D; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign dout = sr[D-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder: skews lane i by i extra cycles so vectors enter the array
// diagonally, and holds off upstream until a finished tile has drained.
module systolic_skew_feeder
    import matmul_pkg::*;
#(
    parameter int N = MM_N,
    parameter int W = MM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic             in_last,
    output logic [N*W-1:0]   out_data,
    output logic [N-1:0]     out_valid,
    output logic             tile_done
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    feed_state_t   state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          drain_end;

    assign in_ready  = (state != DRAIN);
    assign accept    = in_valid & in_ready;
    // The edge that leaves DRAIN is the one loading the last element
    // into lane N-1, so the registered pulse lines up with it.
    assign drain_end = (state == DRAIN) && (cnt == CNT_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= drain_end;
            unique case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (in_last) begin
                            state <= DRAIN;
                            cnt   <= DRAIN_LOAD;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int LO = lane_lo(i, W);

        logic [W:0] lin;
        logic [W:0] lout;

        // Non-accepting edges push a zeroed bubble so idle lanes read 0.
        assign lin = {accept, accept ? in_data[LO +: W] : {W{1'b0}}};

        skew_lane_delay #(
            .D  (i + 1),
            .WD (W + 1)
        ) u_dly (
            .clk   (clk),
            .reset (reset),
            .din   (lin),
            .dout  (lout)
        );

        assign out_valid[i]     = lout[W];
        assign out_data[LO +: W] = lout[W-1:0];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: directed tile scenarios plus
// random traffic, checked against a history-based skew model.
module tb_systolic_skew_feeder;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HMAX = 4096;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic           tile_done;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .tile_done (tile_done)
    );

    typedef struct packed {
        logic [N*W-1:0] d;
        logic [N-1:0]   v;
        logic           td;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic           hv [HMAX];
    logic           hl [HMAX];
    logic [N*W-1:0] hd [HMAX];
    int edge_n = 0;
    int floor_e = 0;
    int ready_from = 0;
    bit model_acc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // Lane i after edge e carries whatever was accepted at edge e-i.
    function automatic exp_t predict(input int e);
        exp_t r;
        int k;
        r = '0;
        for (int i = 0; i < N; i++) begin
            k = e - i;
            if (k >= floor_e && hv[k]) begin
                r.v[i] = 1'b1;
                r.d[i*W +: W] = hd[k][i*W +: W];
            end
        end
        k = e - (N - 1);
        if (k >= floor_e && hv[k] && hl[k]) r.td = 1'b1;
        return r;
    endfunction

    task automatic step(input bit v, input logic [N*W-1:0] d, input bit l);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        chk("in_ready", {63'd0, in_ready}, {63'd0, edge_n >= ready_from});
        model_acc = v && (edge_n >= ready_from);
        hv[edge_n] = model_acc;
        hl[edge_n] = model_acc && l;
        hd[edge_n] = model_acc ? d : '0;
        if (model_acc && l) ready_from = edge_n + N;
        exp_q.push_back(predict(edge_n));
        edge_n++;
    endtask

    task automatic send(input logic [N*W-1:0] d, input bit l);
        int tries;
        tries = 0;
        do begin
            step(1'b1, d, l);
            tries++;
        end while (!model_acc && tries < 20);
        if (!model_acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: beat %0h never accepted", d);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            step(1'b0, $urandom, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {60'd0, out_valid}, 64'd0);
        chk({tag, "_out_data"}, {32'd0, out_data}, 64'd0);
        chk({tag, "_tile_done"}, {63'd0, tile_done}, 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: no expectation at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_valid", {60'd0, out_valid}, {60'd0, e.v});
                    chk("out_data", {32'd0, out_data}, {32'd0, e.d});
                    chk("tile_done", {63'd0, tile_done}, {63'd0, e.td});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;

        idle(2);
        send(32'h44332211, 1'b1);
        idle(5);

        send(32'hA3A2A1A0, 1'b0);
        send(32'hB3B2B1B0, 1'b0);
        send(32'hC3C2C1C0, 1'b1);
        send(32'hD3D2D1D0, 1'b1);
        idle(5);

        send(32'h04030201, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        send(32'h08070605, 1'b1);
        idle(5);

        send(32'h0D0C0B0A, 1'b1);
        send(32'hFFFFFFFF, 1'b1);
        idle(5);

        send(32'h55667788, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_outputs("mid_drain");
        exp_q.delete();
        floor_e = edge_n;
        ready_from = 0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        send(32'h44332211, 1'b1);
        idle(5);

        idle(10);

        for (int j = 0; j < 400; j++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 3) == 0);
        end
        idle(6);

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
